// File: rtl/multicycle_mdu.sv
// Multi-cycle RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider.
// The divider datapath is built only when MULTICYCLE_MDU_DIV_EN is defined; otherwise divides return 0.
module multicycle_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            hi_q, hi_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;

  logic            accept;
  logic            last;
  logic            a_sgn, b_neg;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   prod_nx;

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last   = (cnt_q == CW'(XLEN - 1));

  // Negative multipliers are folded into the multiplicand so only 32 add steps are needed.
  assign a_sgn   = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
  assign b_neg   = (funct3[1:0] == 2'b01) && rs2_val[31];
  assign a_ext   = {{XLEN{a_sgn & rs1_val[31]}}, rs1_val};
  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MULTICYCLE_MDU_DIV_EN
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            isrem_q, isrem_d;

  logic            div_sgn, div_zero, div_ovf, ge;
  logic [XLEN-1:0] a_mag, b_mag, rem_nx, quo_nx;
  logic [XLEN:0]   shifted;

  assign div_sgn  = ~funct3[0];
  assign div_zero = (rs2_val == '0);
  assign div_ovf  = div_sgn && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
  assign a_mag    = (div_sgn && rs1_val[31]) ? -rs1_val : rs1_val;
  assign b_mag    = (div_sgn && rs2_val[31]) ? -rs2_val : rs2_val;

  // One restoring step: quotient register shifts dividend bits into the partial remainder.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = (shifted >= {1'b0, dvsr_q});
  assign rem_nx  = ge ? XLEN'(shifted - {1'b0, dvsr_q}) : shifted[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ge};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef MULTICYCLE_MDU_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      isrem_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef MULTICYCLE_MDU_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      isrem_q  <= isrem_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    hi_d     = hi_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef MULTICYCLE_MDU_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    isrem_d  = isrem_q;
`endif

    unique case (state_q)
      S_MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          state_d  = S_DONE;
          result_d = hi_q ? prod_nx[PW-1:XLEN] : prod_nx[XLEN-1:0];
        end
      end
`ifdef MULTICYCLE_MDU_DIV_EN
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d  = S_DONE;
          result_d = isrem_q ? (rneg_q ? -rem_nx : rem_nx)
                             : (qneg_q ? -quo_nx : quo_nx);
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Accepting a start overrides the DONE->IDLE return so back-to-back ops lose no cycle.
    if (accept) begin
      cnt_d = '0;
      if (!funct3[2]) begin
        state_d  = S_MUL;
        hi_d     = (funct3[1:0] != 2'b00);
        prod_d   = '0;
        mcand_d  = b_neg ? -a_ext : a_ext;
        mplier_d = b_neg ? -rs2_val : rs2_val;
      end else begin
`ifdef MULTICYCLE_MDU_DIV_EN
        if (div_zero) begin
          state_d  = S_DONE;
          result_d = funct3[1] ? rs1_val : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          state_d  = S_DONE;
          result_d = funct3[1] ? 32'h0 : 32'h8000_0000;
        end else begin
          state_d = S_DIV;
          rem_d   = '0;
          quo_d   = a_mag;
          dvsr_d  = b_mag;
          qneg_d  = div_sgn && (rs1_val[31] ^ rs2_val[31]);
          rneg_d  = div_sgn && rs1_val[31];
          isrem_d = funct3[1];
        end
`else
        state_d  = S_DONE;
        result_d = '0;
`endif
      end
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_multicycle_mdu.sv
// Self-checking bench for multicycle_mdu: arithmetic reference model plus directed literal vectors.
// Divide expectations follow MULTICYCLE_MDU_DIV_EN as the design build does.
module tb_multicycle_mdu;

`ifdef MULTICYCLE_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        busy;
  logic        done;
  logic [31:0] result;

  always #5 clk = ~clk;

  multicycle_mdu dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from plain 64-bit arithmetic; bit 32 marks the one-cycle fast path.
  function automatic logic [32:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    int          ia, ib;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    p  = '0;
    case (f)
      3'b000:  p = 64'(ua * ub);
      3'b001:  p = 64'(sa * sb);
      3'b010:  p = 64'(sa * ub);
      3'b011:  p = 64'(ua * ub);
      default: p = '0;
    endcase
    if (f == 3'b000) return {1'b0, p[31:0]};
    if (!f[2]) return {1'b0, p[63:32]};
    if (!DIV_EN) return {1'b1, 32'h0};
    if (b == 32'h0) return {1'b1, f[1] ? a : 32'hFFFF_FFFF};
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {1'b1, f[1] ? 32'h0 : 32'h8000_0000};
    case (f[1:0])
      2'b00:   return {1'b0, 32'(ia / ib)};
      2'b01:   return {1'b0, a / b};
      2'b10:   return {1'b0, 32'(ia % ib)};
      default: return {1'b0, a % b};
    endcase
  endfunction

  // Cycle-level expectation: a countdown per accepted op, result visible only when it completes.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;
  int          m_rem  = 0;
  logic [32:0] m_r;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = '0;
      m_rem  = 0;
    end else if (start && !m_busy) begin
      m_r = ref_op(funct3, rs1_val, rs2_val);
      if (m_r[32]) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_r[31:0];
      end else begin
        m_busy = 1'b1;
        m_done = 1'b0;
        m_pend = m_r[31:0];
        m_rem  = 32;
      end
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",   32'(busy), 32'(m_busy));
      check("cyc_done",   32'(done), 32'(m_done));
      check("cyc_result", result,    m_res);
    end
  end

  // Wait (bounded) from cycle 'from' until done is seen; returns the cycle index of done.
  task automatic wait_done(input int from, output int cyc, output int nbusy);
    cyc   = from;
    nbusy = 0;
    while (!done && cyc < from + 100) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int cyc, nbusy;
    @(negedge clk);
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, cyc, nbusy);
    check({name, "_done"}, 32'(done), 32'd1);
    if (done) begin
      check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({name, "_result"}, result, exp_r);
      check({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    end
  endtask

  int cyc, nbusy, npulse;
  logic [32:0] r;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    funct3  = '0;
    rs1_val = '0;
    rs2_val = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result,    32'h0);
    reset = 1'b0;

    // Multiply vectors
    run_op("mul_7xm3",     3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh_m1m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhu_m1m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu_min",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

    // Divide vectors (normal path and fast paths)
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'h2, DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 33 : 1);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'h2, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 33 : 1);
    run_op("divu_100_7", 3'b101, 32'd100,       32'd7, DIV_EN ? 32'd14 : 32'h0,        DIV_EN ? 33 : 1);
    run_op("remu_100_7", 3'b111, 32'd100,       32'd7, DIV_EN ? 32'd2 : 32'h0,         DIV_EN ? 33 : 1);
    run_op("div_min_2",  3'b100, 32'h8000_0000, 32'h2, DIV_EN ? 32'hC000_0000 : 32'h0, DIV_EN ? 33 : 1);
    run_op("rem_min_3",  3'b110, 32'h8000_0000, 32'h3, DIV_EN ? 32'hFFFF_FFFE : 32'h0, DIV_EN ? 33 : 1);
    run_op("div_by0",    3'b100, 32'h1234_5678, 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1);
    run_op("rem_by0",    3'b110, 32'h1234_5678, 32'h0, DIV_EN ? 32'h1234_5678 : 32'h0, 1);
    run_op("divu_by0",   3'b101, 32'hDEAD_BEEF, 32'h0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1);
    run_op("remu_by0",   3'b111, 32'hDEAD_BEEF, 32'h0, DIV_EN ? 32'hDEAD_BEEF : 32'h0, 1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'h0, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    r = ref_op(3'b101, 32'hFFFF_FFFF, 32'h1);
    run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'h1, r[31:0], r[32] ? 1 : 33);

    // Start re-pulsed mid-MUL is ignored; start in the DONE cycle chains immediately
    @(negedge clk);
    funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    funct3 = 3'b011; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'h9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, cyc, nbusy);
    check("repulse_latency", 32'(cyc), 32'd33);
    check("repulse_result",  result,   32'd15);
    funct3 = 3'b001; rs1_val = 32'h0001_0000; rs2_val = 32'h0001_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, cyc, nbusy);
    check("b2b_latency", 32'(cyc), 32'd33);
    check("b2b_result",  result,   32'h0000_0001);

    // Reset during a divide abandons it with no done pulse
    @(negedge clk);
    funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy",   32'(busy), 32'd0);
    check("midreset_done",   32'(done), 32'd0);
    check("midreset_result", result,    32'h0);
    reset  = 1'b0;
    npulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("midreset_no_done", 32'(npulse), 32'd0);

    // Reset wins over a simultaneous start
    run_op("mul_pre", 3'b000, 32'd6, 32'd7, 32'd42, 33);
    @(negedge clk);
    reset = 1'b1; funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio_busy",   32'(busy), 32'd0);
    check("rst_prio_result", result,    32'h0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_mdu.md
MULTICYCLE_MDU -- requirements
Module: multicycle_mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin an operation, issued by the control FSM during R-type execute.
REQ-004 SHALL have port funct3, input, 3 bits: operation select, 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port rs1_val, input, 32 bits: operand A, dividend for divide operations.
REQ-006 SHALL have port rs2_val, input, 32 bits: operand B, divisor for divide operations.
REQ-007 SHALL have port busy, output, 1 bit: operation in progress, high in states MUL and DIV only.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse meaning result is valid, high in state DONE only.
REQ-009 SHALL have port result, output, 32 bits: registered result, held until the next accepted start or reset.

Function
REQ-010 SHALL implement four states: IDLE, MUL, DIV and DONE.
REQ-011 SHALL accept start only in IDLE or DONE, and SHALL capture funct3, rs1_val and rs2_val on the accepting edge.
REQ-012 SHALL ignore start while busy=1, with no state, operand or result change.
REQ-013 SHALL go to MUL on accepted start when funct3[2]=0.
REQ-014 SHALL go to DIV on accepted start when funct3[2]=1, subject to REQ-020.
REQ-015 SHALL, in MUL, do radix-2 shift-add on 33-bit sign/zero-extended operands for exactly 32 cycles, then go to DONE.
  - Signedness: MULH signed x signed; MULHSU signed x unsigned; MULHU and MUL unsigned x unsigned.
REQ-016 SHALL set result to product[31:0] for MUL and to product[63:32] for MULH, MULHSU and MULHU.
REQ-017 SHALL, in DIV, do restoring division on operand magnitudes for exactly 32 cycles, then go to DONE.
  - DIV and REM: negate the quotient when operand signs differ; the remainder takes the dividend sign.
REQ-018 SHALL give a normal-path latency of 33 cycles: start high in cycle 0, done high in cycle 33.
REQ-019 SHALL, for divide by zero, return quotient 0xFFFFFFFF for DIV and DIVU, and remainder = rs1_val for REM and REMU.
REQ-020 SHALL, for divide by zero and signed overflow, skip the DIV state and go from the accepting edge straight to DONE (done in cycle 1).
  - Signed overflow is 0x80000000 / 0xFFFFFFFF: DIV result 0x80000000, REM result 0.
REQ-021 SHALL leave DONE after one cycle, to IDLE, or to MUL/DIV when start is accepted in DONE, so back-to-back operations lose no cycle.
REQ-022 SHALL update result only on entry to DONE.
REQ-023 SHALL make all outputs registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, force state IDLE, busy=0, done=0, result=0x00000000 and clear the internal counter and accumulators.
REQ-025 SHALL, if reset occurs mid-operation, abandon the operation with no done pulse.
REQ-026 SHALL give reset priority over a simultaneous start.

Configuration
REQ-027 SHALL compile the divider datapath (DIV state, remainder/quotient registers, sign fix-up) only when macro MULTICYCLE_MDU_DIV_EN is defined.
REQ-028 SHALL, without MULTICYCLE_MDU_DIV_EN, send funct3[2]=1 requests from the accepting edge to DONE with result 0x00000000 (done in cycle 1); multiply behaviour SHALL be unchanged.

Verification
REQ-029 SHALL cover: MUL rs1=0x00000007, rs2=0xFFFFFFFD -> done in cycle 33, result 0xFFFFFFEB; busy high in cycles 1-32.
REQ-030 SHALL cover: MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU same operands -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 SHALL cover: DIV x/0 with rs1=0x12345678 -> done in cycle 1, result 0xFFFFFFFF; REM x/0 -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1.
REQ-033 SHALL cover: start re-pulsed at cycle 10 of a MUL -> ignored, original result at cycle 33; new start in the DONE cycle -> next done exactly 33 cycles later.
REQ-034 SHALL cover: reset at cycle 15 of a DIV -> next cycle state IDLE, busy=0, result=0, no done pulse; repeat the DIV build without MULTICYCLE_MDU_DIV_EN -> result 0 in cycle 1.
